// File: rtl/pdm_sample_pacer.sv
// pdm_sample_pacer: buffers signed 16-bit audio samples in a small FIFO and
// releases one per DIV-clock sample period. Each released sample is scaled
// by an unsigned volume, saturated, and held on a registered duty output.
// Optional feature macro: UNDERRUN_MUTE_EN (forces duty to silence on underrun).
//
// Handshake: a sample transfers at a rising clk edge where smpl_vld and
// smpl_rdy are both high. smpl_rdy depends only on rst and registered
// occupancy, never on smpl_vld, so the producer may hold smpl_vld high
// and wait.
module pdm_sample_pacer #(
   parameter int DEPTH = 8,
   parameter int DIV   = 1024,
   parameter int VOL_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              smpl_in,
   input  logic                     smpl_vld,
   output logic                     smpl_rdy,
   input  logic [VOL_W-1:0]         volume,
   output logic [15:0]              duty,
   output logic                     duty_upd,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     underrun
);

   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = $clog2(DIV);
   localparam int PROD_W = 16 + VOL_W + 1;
   localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
   localparam logic signed [PROD_W-1:0] SAT_MIN = -PROD_W'(32768);

   logic [15:0]       mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     pace_cnt;
   logic              strobe;
   logic              push;
   logic              pop;
   logic signed [PROD_W-1:0] head_ext;
   logic signed [PROD_W-1:0] vol_ext;
   logic signed [PROD_W-1:0] product;
   logic signed [PROD_W-1:0] scaled;
   logic [15:0]       sat_val;

   assign smpl_rdy = ~rst & (fifo_cnt != (PW + 1)'(DEPTH));
   assign strobe   = (pace_cnt == CW'(DIV - 1));
   assign push     = smpl_vld & smpl_rdy;
   assign pop      = strobe & (fifo_cnt != '0);

   // Scale the FIFO head by volume at full width, shift down by unity gain
   // (arithmetic shift floors toward -inf), then clamp to the 16-bit range.
   always_comb begin
      head_ext = PROD_W'($signed(mem[rd_ptr]));
      vol_ext  = PROD_W'($signed({1'b0, volume}));
      product  = head_ext * vol_ext;
      scaled   = product >>> (VOL_W - 1);
      if (scaled > SAT_MAX)
         sat_val = 16'h7FFF;
      else if (scaled < SAT_MIN)
         sat_val = 16'h8000;
      else
         sat_val = scaled[15:0];
   end

   // Free-running sample-period counter; wraps at DIV-1 regardless of FIFO state.
   always_ff @(posedge clk) begin
      if (rst)
         pace_cnt <= '0;
      else if (strobe)
         pace_cnt <= '0;
      else
         pace_cnt <= pace_cnt + 1'b1;
   end

   // Sample storage; written only on a completed handshake.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= smpl_in;
   end

   // FIFO pointers and occupancy; push and pop in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Output stage: latch the scaled sample on a pop, flag a strobe that finds
   // the FIFO empty. The pushed-while-empty sample waits for the next strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty     <= 16'h0000;
         duty_upd <= 1'b0;
         underrun <= 1'b0;
      end else begin
         duty_upd <= 1'b0;
         if (pop) begin
            duty     <= sat_val;
            duty_upd <= 1'b1;
         end else if (strobe) begin
            underrun <= 1'b1;
`ifdef UNDERRUN_MUTE_EN
            if (duty != 16'h0000) begin
               duty     <= 16'h0000;
               duty_upd <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_pdm_sample_pacer.sv
// Bench for pdm_sample_pacer: directed scenarios followed by random traffic,
// checked against a queue-based reference model and an expected-duty scoreboard.
module tb_pdm_sample_pacer;

   localparam int DEPTH = 8;
   localparam int DIV   = 16;
   localparam int VOL_W = 8;
   localparam int UNITY = 2 ** (VOL_W - 1);

   logic                   clk;
   logic                   rst;
   logic [15:0]            smpl_in;
   logic                   smpl_vld;
   logic                   smpl_rdy;
   logic [VOL_W-1:0]       volume;
   logic [15:0]            duty;
   logic                   duty_upd;
   logic [$clog2(DEPTH):0] fifo_cnt;
   logic                   underrun;

   pdm_sample_pacer #(.DEPTH(DEPTH), .DIV(DIV), .VOL_W(VOL_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .smpl_in  (smpl_in),
      .smpl_vld (smpl_vld),
      .smpl_rdy (smpl_rdy),
      .volume   (volume),
      .duty     (duty),
      .duty_upd (duty_upd),
      .fifo_cnt (fifo_cnt),
      .underrun (underrun)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model state ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] model_q[$];
   int          edge_n = 0;
   bit          exp_underrun = 1'b0;
   bit          exp_upd = 1'b0;
   logic [15:0] model_duty = 16'h0000;
   bit          started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference gain: exact product, floor division by unity gain, clamp.
   function automatic logic [15:0] ref_gain(input int s, input int v);
      longint p;
      longint q;
      p = longint'(s) * longint'(v);
      if (p >= 0) q = p / UNITY;
      else        q = -((-p + UNITY - 1) / UNITY);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return 16'(q);
   endfunction

   // Reference model: strobe every DIV-th clock after reset, queue semantics.
   always @(posedge clk) begin
      started = 1'b1;
      if (rst) begin
         model_q.delete();
         edge_n       = 0;
         exp_underrun = 1'b0;
         exp_upd      = 1'b0;
         model_duty   = 16'h0000;
      end else begin
         bit do_push;
         edge_n++;
         exp_upd = 1'b0;
         do_push = smpl_vld && (model_q.size() < DEPTH);
         if (edge_n % DIV == 0) begin
            if (model_q.size() > 0) begin
               logic [15:0] s;
               s          = model_q.pop_front();
               model_duty = ref_gain(int'($signed(s)), int'(volume));
               exp_upd    = 1'b1;
               exp_q.push_back(model_duty);
            end else begin
               exp_underrun = 1'b1;
`ifdef UNDERRUN_MUTE_EN
               if (model_duty != 16'h0000) begin
                  model_duty = 16'h0000;
                  exp_upd    = 1'b1;
                  exp_q.push_back(16'h0000);
               end
`endif
            end
         end
         if (do_push)
            model_q.push_back(smpl_in);
      end
   end

   // Monitor: compare all outputs every cycle on the falling edge.
   always @(negedge clk) begin
      if (started) begin
         check("fifo_cnt", 32'(fifo_cnt), 32'(model_q.size()));
         check("smpl_rdy", 32'(smpl_rdy), 32'(!rst && model_q.size() != DEPTH));
         check("underrun", 32'(underrun), 32'(exp_underrun));
         check("duty_hold", 32'(duty), 32'(model_duty));
         check("duty_upd", 32'(duty_upd), 32'(exp_upd));
         if (duty_upd) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL duty_sb: got unexpected update %0h expected none at %0t", duty, $time);
            end else begin
               check("duty_sb", 32'(duty), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] data);
      bit ok;
      bit done;
      done     = 1'b0;
      smpl_in  = data;
      smpl_vld = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         ok = smpl_rdy;
         step(1);
         if (ok) done = 1'b1;
      end
      smpl_vld = 1'b0;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_timeout: got no acceptance expected acceptance of %0h", data);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      step(n);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [15:0] g_smp [4] = '{16'h7000, 16'h9000, 16'h0100, 16'hFFFD};
   logic [7:0]  g_vol [4] = '{8'd255, 8'd255, 8'd64, 8'd64};

   initial begin
      rst      = 1'b1;
      smpl_vld = 1'b1;
      smpl_in  = 16'h5555;
      volume   = 8'(UNITY);
      step(3);
      rst      = 1'b0;
      smpl_vld = 1'b0;
      step(1);

      // Unity gain, two samples, one per period
      push(16'h1234);
      push(16'hEDCC);
      step(40);

      // Gain and saturation corners
      for (int i = 0; i < 4; i++) begin
         volume = g_vol[i];
         push(g_smp[i]);
         step(18);
      end
      volume = 8'(UNITY);

      // Underrun with nothing buffered, then recovery
      do_reset(1);
      step(50);
      push(16'h0400);
      step(20);

      // Fill the FIFO, then hold a 9th sample until a pop frees a slot
      do_reset(1);
      for (int i = 0; i < DEPTH; i++)
         push(16'(16'h0100 * (i + 1)));
      step(2);
      push(16'h0A0A);
      step(2);

      // Simultaneous push and pop with one sample buffered
      do_reset(1);
      push(16'h1111);
      for (int t = 0; t < 2 * DIV && ((edge_n + 1) % DIV) != 0; t++)
         step(1);
      smpl_in  = 16'h2222;
      smpl_vld = 1'b1;
      step(1);
      smpl_vld = 1'b0;
      step(40);

      // Mid-stream reset flushes buffered samples and clears duty
      push(16'h3000);
      push(16'h3001);
      push(16'h3002);
      step(20);
      do_reset(1);
      step(5);

      // Random traffic: alternating heavy and light producer rates
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 250; c++) begin
            if (ph % 2 == 0) smpl_vld = ($urandom_range(0, 3) != 0);
            else             smpl_vld = ($urandom_range(0, 31) == 0);
            smpl_in = 16'($urandom);
            if ($urandom_range(0, 63) == 0) volume = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step(1);
         end
      end
      rst      = 1'b0;
      smpl_vld = 1'b0;
      step(20);

      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
